// File: rtl/fifo_wr_frontend.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : fifo_wr_frontend
// Description : Write-side ingress stage that sits in front of the async FIFO
//               write-pointer block, in the write clock domain. Incoming
//               valid/ready words pass through a 2-entry skid buffer and are
//               then written to the FIFO memory with (w_inc, w_data).
//               A shadow binary write pointer and the synchronised gray read
//               pointer give a local occupancy figure. Writes are gated on
//               that figure, so the FIFO full flag is never the only guard,
//               even though it lags the write pointer by one cycle.
//
// Ports       : w_clk        write-domain clock
//               w_rst        synchronous active-high reset
//               in_data      ingress data word
//               in_valid     ingress word valid
//               in_ready     ingress ready (skid buffer not full)
//               w_data       word for the FIFO memory, valid with w_inc
//               w_inc        FIFO write strobe
//               full         full flag from the FIFO write-pointer block
//               sync_rd_ptr  gray read pointer, already in w_clk domain
//               fill_level   registered occupancy, 0..DEPTH
//               almost_full  registered, fill_level >= AF_THRESH
//               stall_cnt    saturating count of blocked-write cycles
//
// Revision    : 1.0 - initial release
// ============================================================================
module fifo_wr_frontend #(
    parameter int D_SIZE    = 8,
    parameter int P_SIZE    = 4,
    parameter int AF_THRESH = 6
) (
    input  logic              w_clk,
    input  logic              w_rst,
    input  logic [D_SIZE-1:0] in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic [D_SIZE-1:0] w_data,
    output logic              w_inc,
    input  logic              full,
    input  logic [P_SIZE-1:0] sync_rd_ptr,
    output logic [P_SIZE-1:0] fill_level,
    output logic              almost_full,
    output logic [15:0]       stall_cnt
);

    localparam int                DEPTH   = 1 << (P_SIZE - 1);
    localparam logic [P_SIZE-1:0] c_DEPTH = P_SIZE'(DEPTH);
    localparam logic [P_SIZE-1:0] c_AF    = P_SIZE'(AF_THRESH);

    // Skid buffer: r_buf0 is always the head (oldest) entry.
    logic [D_SIZE-1:0] r_buf0;
    logic [D_SIZE-1:0] r_buf1;
    logic [1:0]        r_cnt;

    logic [P_SIZE-1:0] r_wbin;
    logic [P_SIZE-1:0] r_fill;
    logic              r_af;
    logic [15:0]       r_stall;

    logic [P_SIZE-1:0] w_rbin;
    logic [P_SIZE-1:0] w_local_fill;
    logic              w_space_ok;
    logic              w_wr_en;
    logic              w_push;
    logic              w_wr_slot;

    // Gray to binary: each bit is the XOR of all gray bits at or above it.
    always_comb begin
        w_rbin = '0;
        w_rbin[P_SIZE-1] = sync_rd_ptr[P_SIZE-1];
        for (int i = P_SIZE - 2; i >= 0; i--) begin
            w_rbin[i] = w_rbin[i+1] ^ sync_rd_ptr[i];
        end
    end

    // Modulo subtraction covers wrap of either pointer.
    assign w_local_fill = r_wbin - w_rbin;
    assign w_space_ok   = (w_local_fill < c_DEPTH);

    assign in_ready = (r_cnt != 2'd2);
    assign w_push   = in_valid && in_ready;
    assign w_wr_en  = (r_cnt != 2'd0) && !full && w_space_ok;

    // A new word lands behind whatever survives this cycle's pop: slot 1
    // only when one entry is held and it is not leaving.
    assign w_wr_slot = (r_cnt == 2'd1) && !w_wr_en;

    assign w_inc       = w_wr_en;
    assign w_data      = r_buf0;
    assign fill_level  = r_fill;
    assign almost_full = r_af;
    assign stall_cnt   = r_stall;

    always_ff @(posedge w_clk) begin
        if (w_rst) begin
            r_cnt  <= 2'd0;
            r_buf0 <= '0;
            r_buf1 <= '0;
        end else begin
            if (w_wr_en) begin
                r_buf0 <= r_buf1;
            end
            // Placed after the pop shift so a push into slot 0 wins.
            if (w_push) begin
                if (w_wr_slot) begin
                    r_buf1 <= in_data;
                end else begin
                    r_buf0 <= in_data;
                end
            end
            case ({w_push, w_wr_en})
                2'b10:   r_cnt <= r_cnt + 2'd1;
                2'b01:   r_cnt <= r_cnt - 2'd1;
                default: r_cnt <= r_cnt;
            endcase
        end
    end

    always_ff @(posedge w_clk) begin
        if (w_rst) begin
            r_wbin  <= '0;
            r_fill  <= '0;
            r_af    <= 1'b0;
            r_stall <= 16'd0;
        end else begin
            if (w_wr_en) begin
                r_wbin <= r_wbin + {{(P_SIZE-1){1'b0}}, 1'b1};
            end
            r_fill <= w_local_fill;
            r_af   <= (w_local_fill >= c_AF);
            if ((r_cnt != 2'd0) && !w_wr_en && (r_stall != 16'hFFFF)) begin
                r_stall <= r_stall + 16'd1;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_fifo_wr_frontend.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_fifo_wr_frontend
// Description : Self-checking bench for fifo_wr_frontend. A queue-based model
//               tracks buffered words, write and read counts; DUT outputs are
//               compared against it every cycle. Directed scenarios add
//               hand-computed literal expectations, then a random phase runs.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fifo_wr_frontend;

    logic       w_clk = 1'b0;
    logic       w_rst = 1'b0;
    logic [7:0] in_data = 8'h00;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [7:0] w_data;
    logic       w_inc;
    logic       full = 1'b0;
    logic [3:0] sync_rd_ptr = 4'h0;
    logic [3:0] fill_level;
    logic       almost_full;
    logic [15:0] stall_cnt;

    fifo_wr_frontend #(.D_SIZE(8), .P_SIZE(4), .AF_THRESH(6)) dut (
        .w_clk       (w_clk),
        .w_rst       (w_rst),
        .in_data     (in_data),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .w_data      (w_data),
        .w_inc       (w_inc),
        .full        (full),
        .sync_rd_ptr (sync_rd_ptr),
        .fill_level  (fill_level),
        .almost_full (almost_full),
        .stall_cnt   (stall_cnt)
    );

    always #5 w_clk = ~w_clk;

    int checks   = 0;
    int failures = 0;

    // Model state
    bit         model_ok  = 0;
    logic [7:0] q[$];          // words held in the skid buffer, oldest first
    int         wr_count  = 0; // words written to the FIFO since reset
    int         rd_count  = 0; // words read out of the FIFO since reset
    int         exp_fill  = 0;
    bit         exp_af    = 0;
    int         exp_stall = 0;
    logic [7:0] dut_data[$];   // words the DUT actually strobed out

    function automatic logic [3:0] gray(input int b);
        logic [3:0] x;
        x = b[3:0];
        return x ^ (x >> 1);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    // One clock cycle: apply inputs, compare outputs, clock, advance model.
    // Entered and left just after a falling edge.
    task automatic cycle(input bit v, input logic [7:0] d, input bit f,
                         input bit r, output bit acc);
        bit e_ready, e_inc;
        int occ;
        in_valid = v; in_data = d; full = f; w_rst = r;
        sync_rd_ptr = gray(rd_count);
        #1;
        occ     = wr_count - rd_count;
        e_ready = (q.size() != 2);
        e_inc   = (q.size() != 0) && !f && (occ < 8);
        if (model_ok) begin
            chk("in_ready", {31'd0, in_ready}, {31'd0, e_ready});
            chk("w_inc", {31'd0, w_inc}, {31'd0, e_inc});
            if (e_inc) chk("w_data", {24'd0, w_data}, {24'd0, q[0]});
            chk("fill_level", {28'd0, fill_level}, exp_fill);
            chk("almost_full", {31'd0, almost_full}, {31'd0, exp_af});
            chk("stall_cnt", {16'd0, stall_cnt}, exp_stall);
        end
        if (w_inc === 1'b1) dut_data.push_back(w_data);
        acc = v && e_ready && !r;
        @(posedge w_clk);
        if (r) begin
            q.delete(); dut_data.delete();
            wr_count = 0; rd_count = 0;
            exp_fill = 0; exp_af = 0; exp_stall = 0;
            model_ok = 1;
        end else begin
            if ((q.size() != 0) && !e_inc && exp_stall < 65535) exp_stall++;
            exp_fill = occ;
            exp_af   = (occ >= 6);
            if (e_inc) begin
                void'(q.pop_front());
                wr_count++;
            end
            if (acc) q.push_back(d);
        end
        @(negedge w_clk);
    endtask

    task automatic idle(input int n, input bit f);
        bit a;
        for (int i = 0; i < n; i++) cycle(0, 8'h00, f, 0, a);
    endtask

    task automatic do_reset(input int n);
        bit a;
        for (int i = 0; i < n; i++) cycle(0, 8'h00, 0, 1, a);
    endtask

    initial begin
        bit   acc;
        int   nxt;
        int   s0;
        @(negedge w_clk);

        // Reset then idle
        do_reset(2);
        chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
        chk("rst_w_inc", {31'd0, w_inc}, 32'd0);
        chk("rst_w_data", {24'd0, w_data}, 32'd0);
        chk("rst_fill", {28'd0, fill_level}, 32'd0);
        chk("rst_af", {31'd0, almost_full}, 32'd0);
        chk("rst_stall", {16'd0, stall_cnt}, 32'd0);

        // Streaming into a FIFO that is never read: exactly 8 writes
        nxt = 1;
        for (int i = 0; i < 14; i++) begin
            cycle(nxt <= 10, 8'(nxt), 0, 0, acc);
            if (acc) nxt++;
        end
        chk("stream_writes", dut_data.size(), 32'd8);
        for (int i = 0; i < 8 && i < dut_data.size(); i++)
            chk("stream_order", {24'd0, dut_data[i]}, i + 1);
        chk("stream_fill", {28'd0, fill_level}, 32'd8);
        chk("stream_af", {31'd0, almost_full}, 32'd1);
        chk("stream_in_ready", {31'd0, in_ready}, 32'd0);
        chk("stream_accepted", nxt, 32'd11);

        // Blocked writes bump the stall counter each cycle
        s0 = int'(stall_cnt);
        idle(3, 0);
        chk("stall_delta", int'(stall_cnt) - s0, 32'd3);

        // Drain 8 reads while continuing the stream to 0x10; wbin wraps
        for (int i = 0; i < 8; i++) begin
            rd_count++;
            for (int k = 0; k < 2; k++) begin
                cycle(nxt <= 16, 8'(nxt), 0, 0, acc);
                if (acc) nxt++;
            end
        end
        idle(4, 0);
        chk("drain_writes", dut_data.size(), 32'd16);
        for (int i = 8; i < 16 && i < dut_data.size(); i++)
            chk("drain_order", {24'd0, dut_data[i]}, i + 1);
        chk("drain_fill", {28'd0, fill_level}, 32'd8);
        chk("drain_in_ready", {31'd0, in_ready}, 32'd1);

        // Simultaneous push and pop
        do_reset(1);
        cycle(1, 8'hA1, 0, 0, acc);
        cycle(1, 8'hA2, 0, 0, acc);
        idle(3, 0);
        chk("pp_count", dut_data.size(), 32'd2);
        if (dut_data.size() == 2) begin
            chk("pp_first", {24'd0, dut_data[0]}, 32'hA1);
            chk("pp_second", {24'd0, dut_data[1]}, 32'hA2);
        end

        // Mid-operation reset with two words buffered
        do_reset(1);
        for (int i = 1; i <= 5; i++) cycle(1, 8'(i), 0, 0, acc);
        idle(1, 0);
        cycle(1, 8'h66, 1, 0, acc);
        cycle(1, 8'h77, 1, 0, acc);
        idle(1, 1);
        chk("mr_fill5", {28'd0, fill_level}, 32'd5);
        chk("mr_cnt2", {31'd0, in_ready}, 32'd0);
        cycle(0, 8'h00, 1, 1, acc);
        chk("mr_in_ready", {31'd0, in_ready}, 32'd1);
        chk("mr_fill", {28'd0, fill_level}, 32'd0);
        chk("mr_stall", {16'd0, stall_cnt}, 32'd0);
        chk("mr_w_inc", {31'd0, w_inc}, 32'd0);
        idle(3, 0);
        chk("mr_no_writes", dut_data.size(), 32'd0);

        // Random traffic
        for (int i = 0; i < 3000; i++) begin
            bit rr;
            rr = ($urandom_range(0, 399) == 0);
            if (!rr && rd_count < wr_count && $urandom_range(0, 2) == 0) rd_count++;
            cycle($urandom_range(0, 3) != 0, 8'($urandom), $urandom_range(0, 4) == 0, rr, acc);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
